flux_rr_scheduler: RTL and testbench
====================================

Name: flux_rr_scheduler

Overview:
- Fair scheduler for a multi-flux dataflow actor (two-operand, one-result) that is shared by FLUX tagged streams.
- Replaces the actor's fixed lowest-index priority with round-robin selection and an optional burst lock.
- Sits between the per-flux FIFO status and the actor. Drives per-flux read strobes, the write strobe and the grant tag; the actor uses the tag to select and tag its data.

Parameters:
- FLUX, 2, number of interleaved data streams (>=2).
- BURST, 4, maximum consecutive firings granted to one flux before rotation (>=1).
- TAG_WIDTH, $clog2(FLUX), grant tag width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-high.
- sched_en  in  1  scheduling enable. 0 = no new firings.
- empty_a  in  FLUX  operand-A FIFO empty, one bit per flux.
- empty_b  in  FLUX  operand-B FIFO empty, one bit per flux.
- full_out  in  FLUX  result FIFO full, one bit per flux.
- read_a  out  FLUX  operand-A read strobe (one-hot or zero).
- read_b  out  FLUX  operand-B read strobe (identical to read_a).
- write  out  1  result write strobe (fire).
- grant_tag  out  TAG_WIDTH  selected flux index. Valid when write=1, else 0.
- busy  out  1  high in LOCK state.

Behaviour:
- Eligibility:
  - elig[i] = !empty_a[i] & !empty_b[i] & !full_out[i].
  - fire = sched_en & |elig & !rst.
- Firing is combinational, in the same cycle as the status inputs; there is zero-cycle latency from eligibility to strobe.
- On fire: write=1, read_a[tag]=read_b[tag]=1, all other strobes 0.
- When not firing, all strobes are 0 and grant_tag=0.
- Registers:
  - ptr: TAG_WIDTH bits, round-robin start index.
  - cur: TAG_WIDTH bits, locked flux.
  - cnt: $clog2(BURST+1) bits, firings within the current burst.
  - state: IDLE / LOCK.
- Reset (rst=1 at clk edge): ptr=0, cur=0, cnt=0, state=IDLE. While rst=1, all outputs are forced to 0. Reset asserted mid-burst abandons the burst; no strobe is emitted in that cycle.
- Tag selection:
  - IDLE: tag = first eligible index scanning ptr, ptr+1, ..., wrapping modulo FLUX.
  - LOCK: if elig[cur], then tag=cur. Otherwise tag = first eligible scanning from cur+1, wrapping.
- Transitions (evaluated on fire only; if no fire, all registers hold):
  - IDLE, fire, BURST=1: ptr <= tag+1 mod FLUX. Stay in IDLE.
  - IDLE, fire, BURST>1: cur <= tag, cnt <= 1, go to LOCK.
  - LOCK, fire with tag==cur, cnt+1==BURST: ptr <= cur+1 mod FLUX, cnt <= 0, go to IDLE.
  - LOCK, fire with tag==cur, otherwise: cnt <= cnt+1.
  - LOCK, fire with tag!=cur (locked flux stalled): the burst is broken. If BURST=1, go to IDLE with ptr <= tag+1. Otherwise cur <= tag, cnt <= 1, stay in LOCK.
- LOCK with no fire: hold cur and cnt. The lock persists across stall cycles and across sched_en=0.
- sched_en=0: no strobes, state frozen. On re-enable, the scheduler resumes where it left off.
- Wrap: index FLUX-1 plus 1 gives 0. Non-power-of-2 FLUX must wrap correctly and never grant an index >= FLUX.
- busy = (state==LOCK).

Optional Feature:
- Macro: FLUX_SCHED_STATS_EN.
- When defined:
  - Adds a stat_sel input (TAG_WIDTH bits) and a stat_cnt output (16 bits).
  - Per-flux 16-bit fire counters, cleared by rst, incremented on each fire of that flux, saturating at 16'hFFFF.
  - stat_cnt = counter[stat_sel], combinational.
- When undefined: the ports and counters do not exist; the core behaviour is identical.

Decomposition:
- Package flux_sched_pkg:
  - sched_state_t enum {IDLE, LOCK}.
  - Function tag_w(flux) returning max(1, $clog2(flux)).
  - Localparam STAT_W=16.
- Sub-module rr_pick (combinational):
  - Inputs: FLUX-bit request vector and start index.
  - Outputs: found flag and index, using rotating priority.
  - Used once with start = (state==LOCK ? cur : ptr). In LOCK, cur wins directly if eligible.

Test Plan:
- FLUX=4, BURST=1, all flux always eligible, 8 cycles -> tags 0,1,2,3,0,1,2,3; write=1 every cycle; read_a==read_b one-hot.
- FLUX=4, BURST=2, all eligible -> tags 0,0,1,1,2,2,3,3; busy=1 on the first cycle of each pair's second firing, then back to IDLE.
- FLUX=4, BURST=4, flux 2 only eligible for 2 cycles, then empty_a[2]=1 while flux 3 is eligible -> tags 2,2,3; cur becomes 3 and cnt=1.
- FLUX=3, BURST=1, elig=3'b101 steady -> tags alternate 0,2,0,2, never 1 and never 3; ptr wraps 2 to 0.
- full_out=4'hF with all operands present -> write=0, read_a=read_b=0, grant_tag=0, registers unchanged. Release full_out[1] -> tag 1 fires that same cycle.
- Mid-LOCK (cur=1, cnt=1), assert rst for one cycle -> outputs 0 during reset. Then with all eligible, the first tag is 0 and state is IDLE. With FLUX_SCHED_STATS_EN, all counters read 0 after reset.

Source files
------------

// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the flux round-robin scheduler.
// Optional feature macro: FLUX_SCHED_STATS_EN (per-flux fire statistics).
package flux_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } sched_state_t;

    localparam int STAT_W = 16;

    // Tag width never collapses to zero, even for degenerate flux counts.
    function automatic int tag_w(input int flux);
        int w;
        w = $clog2(flux);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or after start,
// wrapping modulo FLUX so an index >= FLUX is never produced.
module rr_pick #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = 1
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] start,
    output logic                 found,
    output logic [TAG_WIDTH-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest request wins last.
    always_comb begin : pick_scan
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = FLUX - 1; k >= 0; k--) begin
            cand  = (int'(start) + k) % FLUX;
            found = found | req[cand];
            idx   = req[cand] ? TAG_WIDTH'(cand) : idx;
        end
    end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin scheduler with burst lock for a multi-flux two-operand actor.
// Optional feature macro: FLUX_SCHED_STATS_EN adds stat_sel/stat_cnt and per-flux fire counters.
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int BURST     = 4,
    parameter int TAG_WIDTH = tag_w(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    input  logic [FLUX-1:0]      empty_a,
    input  logic [FLUX-1:0]      empty_b,
    input  logic [FLUX-1:0]      full_out,
    output logic [FLUX-1:0]      read_a,
    output logic [FLUX-1:0]      read_b,
    output logic                 write,
    output logic [TAG_WIDTH-1:0] grant_tag,
    output logic                 busy
`ifdef FLUX_SCHED_STATS_EN
    ,
    input  logic [TAG_WIDTH-1:0] stat_sel,
    output logic [STAT_W-1:0]    stat_cnt
`endif
);

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST - 1);

    logic [FLUX-1:0]      elig_s;
    logic [TAG_WIDTH-1:0] start_s;
    logic [TAG_WIDTH-1:0] pick_s;
    logic                 found_s;
    logic                 fire_s;

    sched_state_t         state_r;
    logic [TAG_WIDTH-1:0] ptr_r;
    logic [TAG_WIDTH-1:0] cur_r;
    logic [CW-1:0]        cnt_r;

    function automatic logic [TAG_WIDTH-1:0] next_idx(input logic [TAG_WIDTH-1:0] i);
        if (i == TAG_WIDTH'(FLUX - 1)) begin
            return '0;
        end else begin
            return i + TAG_WIDTH'(1);
        end
    endfunction

    assign elig_s = ~empty_a & ~empty_b & ~full_out;

    // Scanning from cur in LOCK gives cur first priority, then cur+1 onward.
    assign start_s = (state_r == LOCK) ? cur_r : ptr_r;

    rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_pick (
        .req   (elig_s),
        .start (start_s),
        .found (found_s),
        .idx   (pick_s)
    );

    assign fire_s = sched_en & found_s & ~rst;

    // Zero-latency strobes: the actor consumes in the same cycle as the status.
    always_comb begin
        read_a    = '0;
        write     = 1'b0;
        grant_tag = '0;
        if (fire_s) begin
            read_a    = FLUX'(1) << pick_s;
            write     = 1'b1;
            grant_tag = pick_s;
        end else begin
            read_a    = '0;
            write     = 1'b0;
            grant_tag = '0;
        end
    end

    assign read_b = read_a;
    assign busy   = (state_r == LOCK) & ~rst;

    // Rotation pointer, burst lock and burst counter; all hold when nothing fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            cur_r   <= '0;
            cnt_r   <= '0;
        end else if (fire_s) begin
            case (state_r)
                IDLE: begin
                    if (BURST == 1) begin
                        ptr_r <= next_idx(pick_s);
                    end else begin
                        cur_r   <= pick_s;
                        cnt_r   <= CW'(1);
                        state_r <= LOCK;
                    end
                end
                LOCK: begin
                    if (pick_s == cur_r) begin
                        if (cnt_r == BURST_LAST) begin
                            ptr_r   <= next_idx(cur_r);
                            cnt_r   <= '0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else if (BURST == 1) begin
                        ptr_r   <= next_idx(pick_s);
                        state_r <= IDLE;
                    end else begin
                        // Locked flux stalled: the burst restarts on the new flux.
                        cur_r <= pick_s;
                        cnt_r <= CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef FLUX_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_r [FLUX];

    // Saturating per-flux fire counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FLUX; i++) begin
                stat_r[i] <= '0;
            end
        end else if (fire_s && (stat_r[pick_s] != '1)) begin
            stat_r[pick_s] <= stat_r[pick_s] + STAT_W'(1);
        end
    end

    assign stat_cnt = (int'(stat_sel) < FLUX) ? stat_r[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Self-checking bench: four scheduler configurations share one stimulus stream,
// checked against constant vector tables and a behavioural round-robin model.
module tb_flux_rr_scheduler;

    typedef struct packed {
        logic [3:0] ra;
        logic [3:0] rb;
        logic       wr;
        logic [1:0] tag;
        logic       bz;
    } obs_t;

    typedef struct {
        bit         r;
        bit         en;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] fo;
        logic [7:0] tags;
        logic [3:0] wr;
        logic [3:0] bz;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       sched_en = 1'b0;
    logic [3:0] ea = 4'hF;
    logic [3:0] eb = 4'hF;
    logic [3:0] fo = 4'h0;
    logic [1:0] ssel = 2'd0;

    logic [3:0] ra0, rb0, ra1, rb1, ra2, rb2;
    logic [2:0] ra3, rb3;
    logic       wr0, wr1, wr2, wr3, bz0, bz1, bz2, bz3;
    logic [1:0] tg0, tg1, tg2, tg3;
`ifdef FLUX_SCHED_STATS_EN
    logic [15:0] sc0, sc1, sc2, sc3;
`endif

    flux_rr_scheduler #(.FLUX(4), .BURST(1)) d0 (
        .clk(clk), .rst(rst), .sched_en(sched_en), .empty_a(ea), .empty_b(eb), .full_out(fo),
        .read_a(ra0), .read_b(rb0), .write(wr0), .grant_tag(tg0), .busy(bz0)
`ifdef FLUX_SCHED_STATS_EN
        , .stat_sel(2'd0), .stat_cnt(sc0)
`endif
    );
    flux_rr_scheduler #(.FLUX(4), .BURST(2)) d1 (
        .clk(clk), .rst(rst), .sched_en(sched_en), .empty_a(ea), .empty_b(eb), .full_out(fo),
        .read_a(ra1), .read_b(rb1), .write(wr1), .grant_tag(tg1), .busy(bz1)
`ifdef FLUX_SCHED_STATS_EN
        , .stat_sel(ssel), .stat_cnt(sc1)
`endif
    );
    flux_rr_scheduler #(.FLUX(4), .BURST(4)) d2 (
        .clk(clk), .rst(rst), .sched_en(sched_en), .empty_a(ea), .empty_b(eb), .full_out(fo),
        .read_a(ra2), .read_b(rb2), .write(wr2), .grant_tag(tg2), .busy(bz2)
`ifdef FLUX_SCHED_STATS_EN
        , .stat_sel(2'd0), .stat_cnt(sc2)
`endif
    );
    flux_rr_scheduler #(.FLUX(3), .BURST(1)) d3 (
        .clk(clk), .rst(rst), .sched_en(sched_en), .empty_a(ea[2:0]), .empty_b(eb[2:0]),
        .full_out(fo[2:0]), .read_a(ra3), .read_b(rb3), .write(wr3), .grant_tag(tg3), .busy(bz3)
`ifdef FLUX_SCHED_STATS_EN
        , .stat_sel(2'd0), .stat_cnt(sc3)
`endif
    );

    obs_t obs [4];
    always_comb begin
        obs[0] = {ra0, rb0, wr0, tg0, bz0};
        obs[1] = {ra1, rb1, wr1, tg1, bz1};
        obs[2] = {ra2, rb2, wr2, tg2, bz2};
        obs[3] = {1'b0, ra3, 1'b0, rb3, wr3, tg3, bz3};
    end

    int flux_p  [4] = '{4, 4, 4, 3};
    int burst_p [4] = '{1, 2, 4, 1};

    // Reference model state: rotation start, locked flux, firings in burst.
    int   m_ptr  [4] = '{0, 0, 0, 0};
    int   m_cur  [4] = '{0, 0, 0, 0};
    int   m_cnt  [4] = '{0, 0, 0, 0};
    bit   m_lock [4] = '{0, 0, 0, 0};
    int   hits   [4][4];
    obs_t mexp   [4];

    int   checks = 0;
    int   failures = 0;
    vec_t vt [$];

    task automatic model_step(input int k, output obs_t e);
        int F, B, start, tag, c;
        logic [3:0] el;
        e = '0;
        F = flux_p[k];
        B = burst_p[k];
        if (rst) begin
            m_ptr[k] = 0; m_cur[k] = 0; m_cnt[k] = 0; m_lock[k] = 1'b0;
            for (int s = 0; s < 4; s++) hits[k][s] = 0;
            return;
        end
        el = ~ea & ~eb & ~fo;
        for (int i = F; i < 4; i++) el[i] = 1'b0;
        start = m_lock[k] ? m_cur[k] : m_ptr[k];
        tag = -1;
        for (int off = 0; off < F; off++) begin
            c = (start + off) % F;
            if (tag < 0 && el[c]) tag = c;
        end
        e.bz = m_lock[k];
        if (!sched_en || tag < 0) return;
        e.wr  = 1'b1;
        e.tag = 2'(tag);
        e.ra  = 4'(1 << tag);
        e.rb  = e.ra;
        hits[k][tag]++;
        if (!m_lock[k]) begin
            if (B == 1) m_ptr[k] = (tag + 1) % F;
            else begin m_lock[k] = 1'b1; m_cur[k] = tag; m_cnt[k] = 1; end
        end else if (tag == m_cur[k]) begin
            m_cnt[k]++;
            if (m_cnt[k] == B) begin m_lock[k] = 1'b0; m_ptr[k] = (m_cur[k] + 1) % F; m_cnt[k] = 0; end
        end else if (B == 1) begin
            m_lock[k] = 1'b0; m_ptr[k] = (tag + 1) % F;
        end else begin
            m_cur[k] = tag; m_cnt[k] = 1;
        end
    endtask

    task automatic drive(input bit r, input bit en, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] f);
        @(posedge clk);
        #1;
        rst = r; sched_en = en; ea = a; eb = b; fo = f;
        for (int k = 0; k < 4; k++) model_step(k, mexp[k]);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int k, input int row, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s inst=%0d row=%0d got(ra,rb,wr,tag,busy)=%h/%h/%b/%0d/%b required=%h/%h/%b/%0d/%b",
                     nm, k, row, a.ra, a.rb, a.wr, a.tag, a.bz, e.ra, e.rb, e.wr, e.tag, e.bz);
        end
    endtask

    task automatic add(input bit r, input bit en, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] f, input int t0, input int t1, input int t2, input int t3,
                       input logic [3:0] w, input logic [3:0] z);
        vec_t v;
        v.r = r; v.en = en; v.ea = a; v.eb = b; v.fo = f;
        v.tags = {2'(t3), 2'(t2), 2'(t1), 2'(t0)};
        v.wr = w; v.bz = z;
        vt.push_back(v);
    endtask

    initial begin
        obs_t e;
        logic [1:0] t;
        // Instances: d0 F4/B1, d1 F4/B2, d2 F4/B4, d3 F3/B1; masks are {d3,d2,d1,d0}.
        add(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b1111, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 1, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h0, 2, 1, 0, 2, 4'b1111, 4'b0100);
        add(0, 1, 4'h0, 4'h0, 4'h0, 3, 1, 0, 0, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 2, 1, 1, 4'b1111, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h0, 1, 2, 1, 2, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h0, 2, 3, 1, 0, 4'b1111, 4'b0100);
        add(0, 1, 4'h0, 4'h0, 4'h0, 3, 3, 1, 1, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'hD, 1, 1, 1, 1, 4'b1111, 4'b0000);
        add(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b1111, 4'b0000);
        add(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h2, 0, 0, 0, 0, 4'b1111, 4'b0000);
        add(0, 1, 4'h0, 4'h0, 4'h2, 2, 0, 0, 2, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h2, 3, 2, 0, 0, 4'b1111, 4'b0100);
        add(0, 1, 4'h0, 4'h0, 4'h2, 0, 2, 0, 2, 4'b1111, 4'b0110);
        add(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        add(0, 1, 4'hB, 4'h0, 4'h0, 2, 2, 2, 2, 4'b1111, 4'b0000);
        add(0, 1, 4'hB, 4'h0, 4'h0, 2, 2, 2, 2, 4'b1111, 4'b0110);
        add(0, 1, 4'h7, 4'h0, 4'h0, 3, 3, 3, 0, 4'b0111, 4'b0100);
        add(0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 4'b0000, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h0, 0, 3, 3, 0, 4'b1111, 4'b0110);
        add(0, 1, 4'h0, 4'h0, 4'h0, 1, 0, 3, 1, 4'b1111, 4'b0100);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].r, vt[i].en, vt[i].ea, vt[i].eb, vt[i].fo);
            for (int k = 0; k < 4; k++) begin
                t = vt[i].tags[2*k +: 2];
                e = '0;
                e.bz = vt[i].bz[k];
                if (vt[i].wr[k]) begin
                    e.wr = 1'b1; e.tag = t; e.ra = 4'b0001 << t; e.rb = e.ra;
                end
                check("vec", k, i, obs[k], e);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0,
                  4'($urandom & $urandom), 4'($urandom & $urandom), 4'($urandom & $urandom));
            for (int k = 0; k < 4; k++) check("rand", k, n, obs[k], mexp[k]);
        end

`ifdef FLUX_SCHED_STATS_EN
        drive(0, 0, 4'hF, 4'hF, 4'h0);
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            ssel = 2'(s);
            #1;
            checks++;
            if (sc1 !== 16'(hits[1][s])) begin
                failures++;
                $display("FAIL stat_cnt sel=%0d got=%0d required=%0d", s, sc1, hits[1][s]);
            end
        end
        drive(1, 0, 4'hF, 4'hF, 4'h0);
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            ssel = 2'(s);
            #1;
            checks++;
            if (sc1 !== 16'h0000) begin
                failures++;
                $display("FAIL stat_reset sel=%0d got=%0d required=0", s, sc1);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
